// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: instruction fetch unit with a small in-order queue.
//
// Walks a fetch PC through instruction memory and stores each returned word,
// together with its address, in a DEPTH-entry circular queue. The decode stage
// drains the queue through a valid/ready handshake. A redirect flushes the
// queue, drops any response still in flight and restarts fetch at the new PC.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-low reset
//   MEM_ADDR1    instruction memory read address (word aligned)
//   MEM_READ1    instruction memory read strobe
//   MEM_DOUT1    instruction word, valid the cycle after MEM_READ1
//   REDIRECT     flush request (taken branch/jump/trap)
//   REDIRECT_PC  new fetch address
//   IR_VALID     IR/IR_PC hold a valid instruction
//   IR_READY     decode accepts IR this cycle
//   IR, IR_PC    head instruction and its address (0 when empty)
//   OCCUPANCY    number of stored entries
//
// Build option: define OTTER_FETCH_BYPASS_EN to present a response directly
// on IR when the queue is empty; without it every response is stored first.

module otter_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic [31:0]              MEM_ADDR1,
  output logic                     MEM_READ1,
  input  logic [31:0]              MEM_DOUT1,
  input  logic                     REDIRECT,
  input  logic [31:0]              REDIRECT_PC,
  output logic                     IR_VALID,
  input  logic                     IR_READY,
  output logic [31:0]              IR,
  output logic [31:0]              IR_PC,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(DEPTH);

  // State
  logic [31:0]     pc_q, pc_d;
  logic            pending_q, pending_d;     // read issued last cycle, response due now
  logic [31:0]     pend_pc_q, pend_pc_d;     // address of that read
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] ent_instr_q [DEPTH];
  logic [31:0] ent_pc_q    [DEPTH];

  // Control
  logic            empty;
  logic [CntW:0]   committed;
  logic            mem_read;
  logic            bypass_vld;
  logic            bypass_take;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

  assign empty = (cnt_q == '0);

  // Entries already stored plus the one response still owed by memory.
  assign committed = {1'b0, cnt_q} + {{CntW{1'b0}}, pending_q};

  always_comb begin
    mem_read    = RST && !REDIRECT && (committed < DepthExt);

`ifdef OTTER_FETCH_BYPASS_EN
    bypass_vld  = RST && pending_q && empty;
`else
    bypass_vld  = 1'b0;
`endif

    // A bypassed response that decode accepts is consumed without being stored.
    bypass_take = bypass_vld && !REDIRECT && IR_READY;
    push        = RST && pending_q && !REDIRECT && !bypass_take;
    pop         = RST && !REDIRECT && IR_READY && !empty;
  end

  // Next state
  always_comb begin
    pc_d      = pc_q;
    pending_d = mem_read;
    pend_pc_d = pend_pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    if (mem_read) begin
      pc_d      = pc_q + 32'd4;
      pend_pc_d = pc_q;
    end

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Flush: mem_read is already low, so the in-flight response is dropped.
    if (REDIRECT) begin
      pc_d     = {REDIRECT_PC[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q      <= RESET_VEC;
      pending_q <= 1'b0;
      pend_pc_q <= 32'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      ent_instr_q[wr_ptr_q] <= MEM_DOUT1;
      ent_pc_q[wr_ptr_q]    <= pend_pc_q;
    end
  end

  // Outputs
  always_comb begin
    MEM_ADDR1 = {pc_q[31:2], 2'b00};
    MEM_READ1 = mem_read;
    OCCUPANCY = cnt_q;
    IR_VALID  = RST && !REDIRECT && (!empty || bypass_vld);
    IR        = 32'h0;
    IR_PC     = 32'h0;
    if (!empty) begin
      IR    = ent_instr_q[rd_ptr_q];
      IR_PC = ent_pc_q[rd_ptr_q];
    end else if (bypass_vld) begin
      IR    = MEM_DOUT1;
      IR_PC = pend_pc_q;
    end
  end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue (DEPTH=4, RESET_VEC=0).
// Memory model returns the read address as the instruction word, one cycle
// after the read strobe. Inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.

module tb_otter_fetch_queue;

`ifdef OTTER_FETCH_BYPASS_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_dout = 32'hDEAD_BEEF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [2:0]  occupancy;

  int n_chk = 0;
  int n_err = 0;
  int reads;

  otter_fetch_queue #(
    .DEPTH     (4),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .MEM_ADDR1   (mem_addr),
    .MEM_READ1   (mem_read),
    .MEM_DOUT1   (mem_dout),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .IR_VALID    (ir_valid),
    .IR_READY    (ir_ready),
    .IR          (ir),
    .IR_PC       (ir_pc),
    .OCCUPANCY   (occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem_read ? mem_addr : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch from a freshly flushed state with decode always ready.
  task automatic run_stream(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("stream_occ0", 32'(occupancy), 32'd0);
      check_eq("stream_addr", mem_addr, base + 32'(4 * k));
      check_eq("stream_rd", 32'(mem_read), 32'd1);
      if (k >= Lat) begin
        check_eq("stream_valid", 32'(ir_valid), 32'd1);
        check_eq("stream_ir_pc", ir_pc, base + 32'(4 * (k - Lat)));
        check_eq("stream_ir", ir, base + 32'(4 * (k - Lat)));
      end else begin
        check_eq("stream_novalid", 32'(ir_valid), 32'd0);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ir_ready    = 1'b1;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    check_eq("rst_rd", 32'(mem_read), 32'd0);
    check_eq("rst_valid", 32'(ir_valid), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_ir", ir, 32'd0);
    check_eq("rst_ir_pc", ir_pc, 32'd0);
    next_cycle();

    // Cold start
    rst = 1'b1;
    run_stream(32'h0, 6);

    // Reset pulse with a read in flight, then backpressure
    rst = 1'b0;
    @(negedge clk);
    check_eq("pulse_rd", 32'(mem_read), 32'd0);
    check_eq("pulse_valid", 32'(ir_valid), 32'd0);
    next_cycle();
    rst      = 1'b1;
    ir_ready = 1'b0;
    reads    = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check_eq("bp_occ0", 32'(occupancy), 32'd0);
        check_eq("bp_addr0", mem_addr, 32'h0);
      end
      if (mem_read) reads++;
      next_cycle();
    end
    @(negedge clk);
    check_eq("bp_reads", 32'(reads), 32'd4);
    check_eq("bp_occ_full", 32'(occupancy), 32'd4);
    check_eq("bp_rd_stop", 32'(mem_read), 32'd0);
    check_eq("bp_hold_valid", 32'(ir_valid), 32'd1);
    check_eq("bp_hold_pc", ir_pc, 32'h0);
    check_eq("bp_hold_ir", ir, 32'h0);
    next_cycle();
    ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("drain_valid", 32'(ir_valid), 32'd1);
      check_eq("drain_pc", ir_pc, 32'(4 * k));
      next_cycle();
    end

    // Refill, then reset mid-run with a full queue
    ir_ready = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    check_eq("refill_occ", 32'(occupancy), 32'd4);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(ir_valid), 32'd0);
    check_eq("mid_rst_rd", 32'(mem_read), 32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_occ", 32'(occupancy), 32'd0);
    check_eq("post_rst_valid", 32'(ir_valid), 32'd0);
    check_eq("post_rst_addr", mem_addr, 32'h0);
    check_eq("post_rst_rd", 32'(mem_read), 32'd1);
    next_cycle();

    // Three stored, one in flight; redirect together with an accepting decode
    repeat (3) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    ir_ready    = 1'b1;
    @(negedge clk);
    check_eq("redir_occ_before", 32'(occupancy), 32'd3);
    check_eq("redir_valid", 32'(ir_valid), 32'd0);
    check_eq("redir_rd", 32'(mem_read), 32'd0);
    next_cycle();
    redirect = 1'b0;
    run_stream(32'h0000_0100, 5);

    // Address wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check_eq("wrap_redir_valid", 32'(ir_valid), 32'd0);
    next_cycle();
    redirect = 1'b0;
    run_stream(32'hFFFF_FFFC, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
